// File: rtl/lsu_csr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_csr_sequencer
// Purpose  : Round-robin arbiter and thread serializer between LSU requesters
//            and the single 32-bit thread-banked CSR port. Each granted
//            whole-warp request is split into one CSR access per active
//            thread. Read data is gathered into a per-thread response that
//            is returned with the requester's tag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   LSU_CSR_WR_ACK_EN  defined   : writes return a response (data all zero)
//                      undefined : writes complete silently, FSM goes
//                                  straight back to IDLE
// ----------------------------------------------------------------------------
// Ports (vectors are flattened, requester r / thread t at [r*W +: W]):
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_rw            1 = write, 0 = read
//   req_addr          base CSR address      [NUM_REQS*ADDR_BITS]
//   req_tmask         active thread mask    [NUM_REQS*NUM_THREADS]
//   req_data          per-thread write data [NUM_REQS*NUM_THREADS*32]
//   req_tag           opaque tag            [NUM_REQS*TAG_WIDTH]
//   rsp_valid/ready   response handshake
//   rsp_idx/tag/tmask requester index, echoed tag and mask
//   rsp_data          gathered read data    [NUM_THREADS*32]
//   csr_*             CSR slave port strobes, addresses and data
// ============================================================================
module lsu_csr_sequencer #(
  parameter int NUM_REQS    = 2,
  parameter int NUM_THREADS = 4,
  parameter int ADDR_BITS   = 12,
  parameter int TAG_WIDTH   = 8,
  parameter int IDX_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rw,
  input  logic [NUM_REQS*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQS-1:0]             req_ready,
  output logic                            rsp_valid,
  output logic [IDX_BITS-1:0]             rsp_idx,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  output logic [NUM_THREADS-1:0]          rsp_tmask,
  output logic [NUM_THREADS*32-1:0]       rsp_data,
  input  logic                            rsp_ready,
  output logic                            csr_read_enable,
  output logic [ADDR_BITS-1:0]            csr_read_addr,
  input  logic [31:0]                     csr_read_data,
  output logic                            csr_write_enable,
  output logic [ADDR_BITS-1:0]            csr_write_addr,
  output logic [31:0]                     csr_write_data
);

  localparam int TID_BITS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

`ifdef LSU_CSR_WR_ACK_EN
  localparam logic c_wr_ack_en = 1'b1;
`else
  localparam logic c_wr_ack_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RSP   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_BITS-1:0]       rr_ptr_q, rr_ptr_d;
  logic                      rw_q, rw_d;
  logic [ADDR_BITS-1:0]      addr_q, addr_d;
  logic [NUM_THREADS-1:0]    tmask_q, tmask_d;
  logic [NUM_THREADS-1:0]    rem_q, rem_d;
  logic [NUM_THREADS*32-1:0] data_q, data_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic [IDX_BITS-1:0]       idx_q, idx_d;
  logic [NUM_THREADS*32-1:0] rsp_data_q, rsp_data_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: first valid requester at or above rr_ptr, with wrap.
  // scan carries one extra bit so the wrap test cannot overflow.
  // --------------------------------------------------------------------------
  logic                grant_found;
  logic [IDX_BITS-1:0] grant_idx;
  logic [IDX_BITS:0]   scan;
  logic [IDX_BITS-1:0] scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      scan = {1'b0, rr_ptr_q} + (IDX_BITS+1)'(i);
      if (scan >= (IDX_BITS+1)'(NUM_REQS)) begin
        scan = scan - (IDX_BITS+1)'(NUM_REQS);
      end
      scan_idx = scan[IDX_BITS-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Lowest remaining thread: scanning downward leaves the lowest set bit.
  logic [TID_BITS-1:0] cur_tid;

  always_comb begin
    cur_tid = '0;
    for (int t = NUM_THREADS - 1; t >= 0; t--) begin
      if (rem_q[t]) begin
        cur_tid = TID_BITS'(t);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  logic [ADDR_BITS-1:0] issue_addr;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    tmask_d    = tmask_q;
    rem_d      = rem_q;
    data_d     = data_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    rsp_data_d = rsp_data_q;

    req_ready        = '0;
    csr_read_enable  = 1'b0;
    csr_read_addr    = '0;
    csr_write_enable = 1'b0;
    csr_write_addr   = '0;
    csr_write_data   = '0;
    issue_addr       = addr_q + ADDR_BITS'(cur_tid);

    case (state_q)
      ST_IDLE: begin
        // Ready is suppressed during reset so no requester sees a handshake
        // that the reset is about to discard.
        if (grant_found && !reset) begin
          req_ready[grant_idx] = 1'b1;
          rw_d       = req_rw[grant_idx];
          addr_d     = req_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
          tmask_d    = req_tmask[int'(grant_idx)*NUM_THREADS +: NUM_THREADS];
          rem_d      = req_tmask[int'(grant_idx)*NUM_THREADS +: NUM_THREADS];
          data_d     = req_data[int'(grant_idx)*NUM_THREADS*32 +: NUM_THREADS*32];
          tag_d      = req_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
          idx_d      = grant_idx;
          rsp_data_d = '0;
          rr_ptr_d   = (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0
                                                              : grant_idx + IDX_BITS'(1);
          if (req_tmask[int'(grant_idx)*NUM_THREADS +: NUM_THREADS] != '0) begin
            state_d = ST_ISSUE;
          end else if (req_rw[grant_idx] && !c_wr_ack_en) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RSP;
          end
        end
      end

      ST_ISSUE: begin
        // Strobes are masked during reset so an aborted request leaves no
        // trace on the CSR side.
        if (rw_q) begin
          csr_write_enable = !reset;
          csr_write_addr   = issue_addr;
          csr_write_data   = data_q[int'(cur_tid)*32 +: 32];
        end else begin
          csr_read_enable = !reset;
          csr_read_addr   = issue_addr;
          rsp_data_d[int'(cur_tid)*32 +: 32] = csr_read_data;
        end
        rem_d = rem_q & ~(NUM_THREADS'(1) << cur_tid);
        if (rem_d == '0) begin
          state_d = (rw_q && !c_wr_ack_en) ? ST_IDLE : ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response fields are only driven while the response is presented.
  always_comb begin
    rsp_valid = (state_q == ST_RSP);
    rsp_idx   = rsp_valid ? idx_q : '0;
    rsp_tag   = rsp_valid ? tag_q : '0;
    rsp_tmask = rsp_valid ? tmask_q : '0;
    rsp_data  = rsp_valid ? rsp_data_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      tmask_q    <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      tmask_q    <= tmask_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_csr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_csr_sequencer
// Purpose  : Directed self-checking bench for lsu_csr_sequencer with two
//            requesters, four threads and 12-bit CSR addresses. The CSR
//            model returns 0xA000_0000 + read address. Write-response checks
//            follow LSU_CSR_WR_ACK_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_csr_sequencer;

  localparam int NR = 2;
  localparam int NT = 4;
  localparam int AB = 12;
  localparam int TW = 8;
  localparam int IB = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_rw;
  logic [NR*AB-1:0]  req_addr;
  logic [NR*NT-1:0]  req_tmask;
  logic [NR*NT*32-1:0] req_data;
  logic [NR*TW-1:0]  req_tag;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [IB-1:0]     rsp_idx;
  logic [TW-1:0]     rsp_tag;
  logic [NT-1:0]     rsp_tmask;
  logic [NT*32-1:0]  rsp_data;
  logic              rsp_ready;
  logic              csr_read_enable;
  logic [AB-1:0]     csr_read_addr;
  logic [31:0]       csr_read_data;
  logic              csr_write_enable;
  logic [AB-1:0]     csr_write_addr;
  logic [31:0]       csr_write_data;

  int n_pass  = 0;
  int n_total = 0;

  lsu_csr_sequencer #(
    .NUM_REQS(NR), .NUM_THREADS(NT), .ADDR_BITS(AB), .TAG_WIDTH(TW), .IDX_BITS(IB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_tmask(req_tmask), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_tag(rsp_tag),
    .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .csr_read_enable(csr_read_enable), .csr_read_addr(csr_read_addr),
    .csr_read_data(csr_read_data),
    .csr_write_enable(csr_write_enable), .csr_write_addr(csr_write_addr),
    .csr_write_data(csr_write_data)
  );

  always #5 clk = ~clk;

  assign csr_read_data = 32'hA000_0000 + {20'd0, csr_read_addr};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic rw, input logic [AB-1:0] a,
                         input logic [NT-1:0] m, input logic [127:0] d, input logic [TW-1:0] tg);
    req_valid[i]            = v;
    req_rw[i]               = rw;
    req_addr[i*AB +: AB]    = a;
    req_tmask[i*NT +: NT]   = m;
    req_data[i*128 +: 128]  = d;
    req_tag[i*TW +: TW]     = tg;
  endtask

  // Advance one clock; inputs are changed and outputs sampled at negedge.
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_rw    = '0;
    req_addr  = '0;
    req_tmask = '0;
    req_data  = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    cyc;
    reset = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_strobes", {csr_read_enable, csr_write_enable}, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // ---------------- round robin, tmask 0001 ----------------
    set_req(0, 1'b1, 1'b0, 12'h010, 4'b0001, 128'h0, 8'h10);
    set_req(1, 1'b1, 1'b0, 12'h020, 4'b0001, 128'h0, 8'h11);
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("rr_grant", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
      cyc;
      chk("rr_issue_ready", req_ready, 0);
      chk("rr_rd_en", csr_read_enable, 1);
      chk("rr_rd_addr", csr_read_addr, (g % 2 == 1) ? 12'h020 : 12'h010);
      cyc;
      chk("rr_rsp_idx", {rsp_valid, rsp_idx}, (g % 2 == 1) ? 2'b11 : 2'b10);
      chk("rr_rsp_data", rsp_data, (g % 2 == 1) ? 128'hA000_0020 : 128'hA000_0010);
      cyc;
    end
    req_valid = '0;

    // ---------------- read, addr 0x7C0, tmask 1010 ----------------
    set_req(0, 1'b1, 1'b0, 12'h7C0, 4'b1010, 128'h0, 8'h5A);
    #1;
    chk("rd_grant", req_ready, 2'b01);
    cyc;
    req_valid = '0;
    #1;
    chk("rd_strobe1", {csr_read_enable, csr_write_enable, csr_read_addr}, {2'b10, 12'h7C1});
    cyc;
    chk("rd_strobe2", {csr_read_enable, csr_write_enable, csr_read_addr}, {2'b10, 12'h7C3});
    cyc;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 128'hA000_07C3_0000_0000_A000_07C1_0000_0000);
    chk("rd_rsp_fields", {rsp_idx, rsp_tag, rsp_tmask}, {1'b0, 8'h5A, 4'b1010});
    chk("rd_no_strobe", csr_read_enable, 0);
    cyc;
    chk("rd_rsp_done", rsp_valid, 0);

    // ---------------- stall: rsp_ready low 5 cycles ----------------
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 12'h100, 4'b0001, 128'h0, 8'h77);
    set_req(0, 1'b1, 1'b0, 12'h345, 4'b0000, 128'h0, 8'h33);
    #1;
    chk("st_grant", req_ready, 2'b10);
    cyc;
    req_valid[1] = 1'b0;
    #1;
    chk("st_rd_addr", csr_read_addr, 12'h100);
    cyc;
    for (int s = 0; s < 5; s++) begin
      chk("st_hold_valid", {rsp_valid, rsp_idx, rsp_tag}, {1'b1, 1'b1, 8'h77});
      chk("st_hold_data", rsp_data, 128'hA000_0100);
      chk("st_hold_quiet", {req_ready, csr_read_enable, csr_write_enable}, 0);
      cyc;
    end
    rsp_ready = 1'b1;
    #1;
    chk("st_release_ready", req_ready, 0);
    cyc;
    chk("st_regrant", {rsp_valid, req_ready}, {1'b0, 2'b01});

    // ---------------- zero-mask read ----------------
    cyc;
    req_valid = '0;
    #1;
    chk("z_rsp_valid", rsp_valid, 1);
    chk("z_no_strobe", {csr_read_enable, csr_write_enable}, 0);
    chk("z_rsp_data", rsp_data, 0);
    chk("z_rsp_fields", {rsp_idx, rsp_tag, rsp_tmask}, {1'b0, 8'h33, 4'b0000});
    cyc;

    // ---------------- write, addr 0xFFF wraps ----------------
    set_req(1, 1'b1, 1'b1, 12'hFFF, 4'b0011, 128'h0000_0000_0000_0000_0000_0022_0000_0011, 8'h44);
    #1;
    chk("wr_grant", req_ready, 2'b10);
    cyc;
    req_valid = '0;
    #1;
    chk("wr_strobe1", {csr_write_enable, csr_read_enable, csr_write_addr, csr_write_data},
        {2'b10, 12'hFFF, 32'h11});
    cyc;
    chk("wr_strobe2", {csr_write_enable, csr_read_enable, csr_write_addr, csr_write_data},
        {2'b10, 12'h000, 32'h22});
    cyc;
`ifdef LSU_CSR_WR_ACK_EN
    chk("wr_ack_valid", {rsp_valid, rsp_idx, rsp_tag}, {1'b1, 1'b1, 8'h44});
    chk("wr_ack_data", rsp_data, 0);
    cyc;
`else
    chk("wr_no_rsp", {rsp_valid, csr_write_enable}, 0);
`endif

    // ---------------- reset during second ISSUE cycle ----------------
    set_req(0, 1'b1, 1'b1, 12'h200, 4'b1111,
            128'h0000_0004_0000_0003_0000_0002_0000_0001, 8'h99);
    #1;
    chk("rs_grant", req_ready, 2'b01);
    cyc;
    req_valid = '0;
    #1;
    chk("rs_strobe1", {csr_write_enable, csr_write_addr, csr_write_data},
        {1'b1, 12'h200, 32'h1});
    cyc;
    reset = 1'b1;
    #1;
    chk("rs_strobe_masked", csr_write_enable, 0);
    cyc;
    reset = 1'b0;
    #1;
    chk("rs_outputs_zero", {rsp_valid, req_ready, csr_read_enable, csr_write_enable}, 0);
    chk("rs_rsp_data_zero", rsp_data, 0);
    set_req(0, 1'b1, 1'b0, 12'h050, 4'b0001, 128'h0, 8'h01);
    set_req(1, 1'b1, 1'b0, 12'h060, 4'b0001, 128'h0, 8'h02);
    #1;
    chk("rs_grant_req0", req_ready, 2'b01);
    cyc;
    req_valid = '0;
    #1;
    chk("rs_next_read", {csr_read_enable, csr_write_enable, csr_read_addr}, {2'b10, 12'h050});
    cyc;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
